// File: rtl/cp0_regfile.sv
// CP0 register file: Status/Cause/EPC/BadVAddr, Count/Compare timer, MTC0/MFC0.
// Define CP0_PRID_EN to expose read-only PRId (15) and Config (16).
module cp0_regfile #(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter logic [31:0] PRID_VAL   = 32'h0001_8000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  localparam logic [4:0] A_BADV = 5'd8;
  localparam logic [4:0] A_CNT  = 5'd9;
  localparam logic [4:0] A_CMP  = 5'd11;
  localparam logic [4:0] A_STAT = 5'd12;
  localparam logic [4:0] A_CAUS = 5'd13;
  localparam logic [4:0] A_EPC  = 5'd14;
  localparam logic [4:0] A_PRID = 5'd15;
  localparam logic [4:0] A_CFG  = 5'd16;

  localparam logic [31:0] ST_WMASK = 32'h0000_FF03;

  logic        r_tick;
  logic        r_timer_int;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  logic        w_exc;
  logic        w_eret;
  logic        w_badaddr;
  logic [4:0]  w_code;
  logic        w_wr_cnt;
  logic        w_wr_cmp;
  logic        w_wr_stat;
  logic        w_wr_caus;
  logic        w_wr_epc;
  logic        w_hit;
  logic [31:0] w_epc_new;
  logic [31:0] w_rdata;

  always_comb begin
    w_exc     = 1'b0;
    w_eret    = 1'b0;
    w_badaddr = 1'b0;
    w_code    = 5'd0;
    unique case (1'b1)
      (excepttype_i == 32'h1): begin
        w_exc  = 1'b1;
        w_code = 5'd0;
      end
      (excepttype_i == 32'h4): begin
        w_exc     = 1'b1;
        w_badaddr = 1'b1;
        w_code    = 5'd4;
      end
      (excepttype_i == 32'h5): begin
        w_exc     = 1'b1;
        w_badaddr = 1'b1;
        w_code    = 5'd5;
      end
      (excepttype_i == 32'h8): begin
        w_exc  = 1'b1;
        w_code = 5'd8;
      end
      (excepttype_i == 32'h9): begin
        w_exc  = 1'b1;
        w_code = 5'd9;
      end
      (excepttype_i == 32'ha): begin
        w_exc  = 1'b1;
        w_code = 5'd10;
      end
      (excepttype_i == 32'hc): begin
        w_exc  = 1'b1;
        w_code = 5'd12;
      end
      (excepttype_i == 32'he): begin
        w_eret = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_wr_cnt  = we_i && (waddr_i == A_CNT);
  assign w_wr_cmp  = we_i && (waddr_i == A_CMP);
  assign w_wr_stat = we_i && (waddr_i == A_STAT);
  assign w_wr_caus = we_i && (waddr_i == A_CAUS);
  assign w_wr_epc  = we_i && (waddr_i == A_EPC);

  assign w_hit = (r_compare != 32'd0) && (r_count == r_compare);

  assign w_epc_new = is_in_delayslot_i ?
                     current_inst_addr_i - 32'd4 :
                     current_inst_addr_i;

  // Timer block: Count runs at half the core clock
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tick      <= 1'b0;
      r_count     <= 32'd0;
      r_compare   <= 32'd0;
      r_timer_int <= 1'b0;
    end else begin
      r_tick <= ~r_tick;
      if (w_wr_cnt)
        r_count <= data_i;
      else if (r_tick)
        r_count <= r_count + 32'd1;
      if (w_wr_cmp)
        r_compare <= data_i;
      if (w_wr_cmp)
        r_timer_int <= 1'b0;
      else if (w_hit)
        r_timer_int <= 1'b1;
    end
  end

  // Exceptions win over MTC0 to Status/Cause/EPC/BadVAddr
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_status   <= STATUS_RST;
      r_cause    <= 32'd0;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
    end else begin
      r_cause[15:10] <= {int_i[5] | r_timer_int, int_i[4:0]};
      if (w_exc) begin
        if (!r_status[1]) begin
          r_epc      <= w_epc_new;
          r_cause[31] <= is_in_delayslot_i;
        end
        r_status[1]  <= 1'b1;
        r_cause[6:2] <= w_code;
        if (w_badaddr)
          r_badvaddr <= bad_addr_i;
      end else if (w_eret) begin
        r_status[1] <= 1'b0;
      end else begin
        if (w_wr_stat)
          r_status <= (r_status & ~ST_WMASK) | (data_i & ST_WMASK);
        if (w_wr_caus)
          r_cause[9:8] <= data_i[9:8];
        if (w_wr_epc)
          r_epc <= data_i;
      end
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (raddr_i)
      A_BADV:  w_rdata = r_badvaddr;
      A_CNT:   w_rdata = r_count;
      A_CMP:   w_rdata = r_compare;
      A_STAT:  w_rdata = r_status;
      A_CAUS:  w_rdata = r_cause;
      A_EPC:   w_rdata = r_epc;
`ifdef CP0_PRID_EN
      A_PRID:  w_rdata = PRID_VAL;
      A_CFG:   w_rdata = 32'h8000_0000;
`else
      A_PRID:  w_rdata = 32'd0;
      A_CFG:   w_rdata = 32'd0;
`endif
      default: w_rdata = 32'd0;
    endcase
  end

`ifndef CP0_PRID_EN
  logic w_unused_prid;
  assign w_unused_prid = ^PRID_VAL;
`endif

  assign data_o      = w_rdata;
  assign count_o     = r_count;
  assign compare_o   = r_compare;
  assign status_o    = r_status;
  assign cause_o     = r_cause;
  assign epc_o       = r_epc;
  assign badvaddr_o  = r_badvaddr;
  assign timer_int_o = r_timer_int;

endmodule
